// File: rtl/fetcher_icache.sv
// Per-core instruction fetcher with a small fully-associative instruction cache.
// Hits return in one cycle; misses issue a single read to the program-memory controller.
module fetcher_icache #(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 16,
    parameter int unsigned CACHE_ENTRIES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           core_state,
    input  logic [ADDR_BITS-1:0] current_pc,
    input  logic                 flush,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic [2:0]           fetcher_state,
    output logic [DATA_BITS-1:0] instruction,
    output logic [15:0]          hit_count,
    output logic [15:0]          miss_count
);

    localparam int unsigned IDX_BITS = (CACHE_ENTRIES > 1) ? $clog2(CACHE_ENTRIES) : 1;
    localparam int unsigned CNT_BITS = 16;
    localparam logic [2:0]  CORE_FETCH  = 3'b001;
    localparam logic [2:0]  CORE_DECODE = 3'b010;

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        FETCHING = 3'b001,
        FETCHED  = 3'b010
    } state_t;

    state_t                                  state, state_n;
    logic                                    mem_read_valid_n;
    logic [ADDR_BITS-1:0]                    mem_read_address_n;
    logic [DATA_BITS-1:0]                    instruction_n;
    logic [CNT_BITS-1:0]                     hit_count_n, miss_count_n;
    logic [CACHE_ENTRIES-1:0]                valid, valid_n;
    logic [CACHE_ENTRIES-1:0][ADDR_BITS-1:0] tags, tags_n;
    logic [CACHE_ENTRIES-1:0][DATA_BITS-1:0] lines, lines_n;
    logic [IDX_BITS-1:0]                     rr_ptr, rr_ptr_n;
    logic                                    fill_killed, fill_killed_n;

    logic                                    hit_c;
    logic [IDX_BITS-1:0]                     hit_idx_c;
    logic                                    free_c;
    logic [IDX_BITS-1:0]                     free_idx_c;
    logic [IDX_BITS-1:0]                     fill_idx_c;

    assign fetcher_state = state;

    // Tag match across all valid entries; a tag is never resident twice.
    always_comb begin
        hit_c     = 1'b0;
        hit_idx_c = '0;
        for (int i = 0; i < int'(CACHE_ENTRIES); i++) begin
            if (valid[i] && (tags[i] == current_pc)) begin
                hit_c     = 1'b1;
                hit_idx_c = IDX_BITS'(i);
            end
        end
    end

    // Lowest-index invalid entry, scanned downward so the lowest one wins.
    always_comb begin
        free_c     = 1'b0;
        free_idx_c = '0;
        for (int i = int'(CACHE_ENTRIES) - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_c     = 1'b1;
                free_idx_c = IDX_BITS'(i);
            end
        end
    end

    assign fill_idx_c = free_c ? free_idx_c : rr_ptr;

    // Next-state and registered-output logic.
    always_comb begin
        state_n            = state;
        mem_read_valid_n   = mem_read_valid;
        mem_read_address_n = mem_read_address;
        instruction_n      = instruction;
        hit_count_n        = hit_count;
        miss_count_n       = miss_count;
        valid_n            = valid;
        tags_n             = tags;
        lines_n            = lines;
        rr_ptr_n           = rr_ptr;
        fill_killed_n      = fill_killed;

        if (flush) begin
            valid_n = '0;
        end

        case (state)
            IDLE: begin
                // A still-high ready means the previous response is not retired yet.
                if ((core_state == CORE_FETCH) && !mem_read_ready) begin
                    if (hit_c && !flush) begin
                        instruction_n = lines[hit_idx_c];
                        state_n       = FETCHED;
                        if (hit_count != '1) begin
                            hit_count_n = hit_count + CNT_BITS'(1);
                        end
                    end else begin
                        mem_read_valid_n   = 1'b1;
                        mem_read_address_n = current_pc;
                        state_n            = FETCHING;
                        if (miss_count != '1) begin
                            miss_count_n = miss_count + CNT_BITS'(1);
                        end
                    end
                end
            end

            FETCHING: begin
                if (flush) begin
                    fill_killed_n = 1'b1;
                end
                if (mem_read_ready) begin
                    instruction_n    = mem_read_data;
                    mem_read_valid_n = 1'b0;
                    state_n          = FETCHED;
                    fill_killed_n    = 1'b0;
                    if (!fill_killed && !flush) begin
                        valid_n[fill_idx_c] = 1'b1;
                        tags_n[fill_idx_c]  = mem_read_address;
                        lines_n[fill_idx_c] = mem_read_data;
                        if (!free_c) begin
                            rr_ptr_n = rr_ptr + IDX_BITS'(1);
                        end
                    end
                end
            end

            FETCHED: begin
                if (core_state == CORE_DECODE) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers; reset also abandons any outstanding read.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
            instruction      <= '0;
            hit_count        <= '0;
            miss_count       <= '0;
            valid            <= '0;
            tags             <= '0;
            lines            <= '0;
            rr_ptr           <= '0;
            fill_killed      <= 1'b0;
        end else begin
            state            <= state_n;
            mem_read_valid   <= mem_read_valid_n;
            mem_read_address <= mem_read_address_n;
            instruction      <= instruction_n;
            hit_count        <= hit_count_n;
            miss_count       <= miss_count_n;
            valid            <= valid_n;
            tags             <= tags_n;
            lines            <= lines_n;
            rr_ptr           <= rr_ptr_n;
            fill_killed      <= fill_killed_n;
        end
    end

endmodule
